// File: rtl/arb_pkg.sv
// Shared constants for the round-robin grant arbiter: FSM state encoding and
// the default geometry used by the arbiter and its bench.
package arb_pkg;

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_BUSY = 1'b1;

   localparam int DEF_N        = 4;
   localparam int DEF_IDX_W    = 2;
   localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin winner selection: rotate requests so ptr lands at bit 0,
// fixed-priority encode the lowest set bit, then add ptr back modulo N.
module rr_priority_encoder
   import arb_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_win_idx,
   output logic             o_win_valid
);

   logic [2*N-1:0]   w_dbl;
   logic [N-1:0]     w_rot;
   logic [IDX_W-1:0] w_off;
   logic [IDX_W:0]   w_sum;

   // Shifting a doubled copy gives a rotate-right by ptr without variable indexing.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[N-1:0];

   always_comb begin
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDX_W'(i);
         end
      end
   end

   assign w_sum = {1'b0, w_off} + {1'b0, i_ptr};

   always_comb begin
      if (w_sum >= (IDX_W + 1)'(N)) begin
         o_win_idx = IDX_W'(w_sum - (IDX_W + 1)'(N));
      end else begin
         o_win_idx = w_sum[IDX_W-1:0];
      end
   end

   assign o_win_valid = |i_req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot/binary grant, release on done or
// request drop, and an optional hold timeout that forces the owner off.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N-1:0]     i_req,
   input  logic [N-1:0]     i_done,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_grant_valid,
   output logic             o_timeout
);

   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};
   localparam logic [N-1:0] ONE_HOT_LSB = {{(N - 1){1'b0}}, 1'b1};

   logic              r_state;
   logic [IDX_W-1:0]  r_ptr;
   logic [HOLD_W-1:0] r_hold;
   logic [N-1:0]      r_grant;
   logic [IDX_W-1:0]  r_grant_idx;
   logic              r_grant_valid;
   logic              r_timeout;

   logic [IDX_W-1:0]  w_win_idx;
   logic              w_win_valid;
   logic              w_owner_done;
   logic              w_owner_req;
   logic              w_expire;
   logic              w_release;
   logic [IDX_W-1:0]  w_next_ptr;

   rr_priority_encoder #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_encoder (
      .i_req       (i_req),
      .i_ptr       (r_ptr),
      .o_win_idx   (w_win_idx),
      .o_win_valid (w_win_valid)
   );

   generate
      if (MAX_HOLD == 0) begin : g_no_timeout
         assign w_expire = 1'b0;
      end else begin : g_timeout
         assign w_expire = (r_hold == HOLD_W'(MAX_HOLD - 1));
      end
   endgenerate

   assign w_owner_done = i_done[r_grant_idx];
   assign w_owner_req  = i_req[r_grant_idx];
   assign w_release    = w_owner_done || !w_owner_req || w_expire;
   assign w_next_ptr   = (r_grant_idx == IDX_W'(N - 1)) ? '0 : r_grant_idx + IDX_W'(1);

   // A timeout is reported only when expiry is the sole reason the owner lost the grant.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= STATE_IDLE;
         r_ptr         <= '0;
         r_hold        <= '0;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            STATE_IDLE: begin
               if (w_win_valid) begin
                  r_grant       <= ONE_HOT_LSB << w_win_idx;
                  r_grant_idx   <= w_win_idx;
                  r_grant_valid <= 1'b1;
                  r_hold        <= '0;
                  r_state       <= STATE_BUSY;
               end
            end
            default: begin
               if (w_release) begin
                  r_grant       <= '0;
                  r_grant_idx   <= '0;
                  r_grant_valid <= 1'b0;
                  r_ptr         <= w_next_ptr;
                  r_state       <= STATE_IDLE;
                  r_timeout     <= w_expire && !w_owner_done && w_owner_req;
               end else if (r_hold != HOLD_SAT) begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_idx   = r_grant_idx;
   assign o_grant_valid = r_grant_valid;
   assign o_timeout     = r_timeout;

endmodule
